// File: rtl/axis2bram_capture_v1_0_if.sv
// AXI-Stream bus bundle carrying 48-bit {im, re} beats into the frame capture block.
// The master drives the beat and the slave returns tready.
interface axis2bram_capture_v1_0_if;
    logic [47:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis2bram_capture_v1_0.sv
// axis2bram_capture_v1_0: captures fixed-length AXI-Stream frames into a ping-pong pair
// of memory banks and exposes each completed frame on a registered BRAM-style read port
// with a valid/ack handshake. Framing errors produce one-cycle event pulses.
// Optional macro AXIS2BRAM_POWER_EN: store re^2 + im^2 instead of packed {im, re};
// this adds one write pipeline stage, so frame valid appears one cycle later.
module axis2bram_capture_v1_0 #(
    parameter int p_addr_width = 7,
    parameter int p_lane_lsb   = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    axis2bram_capture_v1_0_if.slave     s_axis,
    input  logic [p_addr_width-1:0]     i_m_bram_add,
    output logic [31:0]                 o32_m_bram_data,
    output logic                        o_m_data_valid,
    input  logic                        i_m_frame_ack,
    output logic                        o_tlast_unexpected,
    output logic                        o_tlast_missing
);
    localparam int N = 1 << p_addr_width;

    // Both banks live in one array; the bank select is the top address bit.
    logic [31:0]             mem [0:2*N-1];

    logic [1:0]              full_reg;
    logic [1:0]              full_next;
    logic                    wr_bank_reg;
    logic                    rd_bank_reg;
    logic [p_addr_width-1:0] idx_reg;
    logic                    tlast_unexpected_reg;
    logic                    tlast_missing_reg;
    logic [31:0]             rd_data_reg;

    logic [15:0]             lane_slice [2];
    logic                    accept;
    logic                    frame_end;
    logic                    early_end;
    logic                    ack_take;

    logic                    mem_we;
    logic [p_addr_width:0]   mem_waddr;
    logic [31:0]             mem_wdata;
    logic                    set_full;
    logic                    set_bank;

    // Bits of the 24-bit lanes outside the stored slice are intentionally dropped.
    logic                    unused_tdata_bits;
    assign unused_tdata_bits = ^s_axis.tdata;

    // Lane 0 is re, lane 1 is im; each keeps a 16-bit window starting at p_lane_lsb.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_lane
            assign lane_slice[gi] = s_axis.tdata[gi*24 + p_lane_lsb +: 16];
        end
    endgenerate

    assign s_axis.tready = !rst && !full_reg[wr_bank_reg];
    assign accept        = s_axis.tvalid && s_axis.tready;
    assign frame_end     = accept && (idx_reg == '1);
    assign early_end     = accept && s_axis.tlast && (idx_reg != '1);
    assign ack_take      = i_m_frame_ack && full_reg[rd_bank_reg];

`ifdef AXIS2BRAM_POWER_EN
    logic                    pipe_valid_reg;
    logic                    pipe_commit_reg;
    logic                    pipe_bank_reg;
    logic [p_addr_width-1:0] pipe_idx_reg;
    logic signed [15:0]      pipe_re_reg;
    logic signed [15:0]      pipe_im_reg;
    logic signed [31:0]      re_ext;
    logic signed [31:0]      im_ext;
    logic [31:0]             re_sq;
    logic [31:0]             im_sq;

    // Register the accepted beat; the commit flag travels with the final word so the
    // bank only reports full once that word is actually in memory.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_valid_reg  <= 1'b0;
            pipe_commit_reg <= 1'b0;
        end else begin
            pipe_valid_reg  <= accept;
            pipe_commit_reg <= frame_end;
        end
        pipe_bank_reg <= wr_bank_reg;
        pipe_idx_reg  <= idx_reg;
        pipe_re_reg   <= lane_slice[0];
        pipe_im_reg   <= lane_slice[1];
    end

    // Exact magnitude squared: each square is at most 2^30, so the sum fits 32 bits unsigned.
    assign re_ext    = {{16{pipe_re_reg[15]}}, pipe_re_reg};
    assign im_ext    = {{16{pipe_im_reg[15]}}, pipe_im_reg};
    assign re_sq     = re_ext * re_ext;
    assign im_sq     = im_ext * im_ext;
    assign mem_we    = pipe_valid_reg;
    assign mem_waddr = {pipe_bank_reg, pipe_idx_reg};
    assign mem_wdata = re_sq + im_sq;
    assign set_full  = pipe_commit_reg;
    assign set_bank  = pipe_bank_reg;
`else
    assign mem_we    = accept;
    assign mem_waddr = {wr_bank_reg, idx_reg};
    assign mem_wdata = {lane_slice[1], lane_slice[0]};
    assign set_full  = frame_end;
    assign set_bank  = wr_bank_reg;
`endif

    // Bank occupancy: a commit and an ack may land together; they never hit the same bank.
    always_comb begin
        full_next = full_reg;
        if (set_full) begin
            full_next[set_bank] = 1'b1;
        end
        if (ack_take) begin
            full_next[rd_bank_reg] = 1'b0;
        end
    end

    // Frame control: write index, bank pointers, occupancy and framing-error pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            full_reg             <= 2'b00;
            wr_bank_reg          <= 1'b0;
            rd_bank_reg          <= 1'b0;
            idx_reg              <= '0;
            tlast_unexpected_reg <= 1'b0;
            tlast_missing_reg    <= 1'b0;
        end else begin
            full_reg <= full_next;
            if (accept) begin
                // Early tlast drops the partial frame and restarts the same bank.
                if (frame_end || s_axis.tlast) begin
                    idx_reg <= '0;
                end else begin
                    idx_reg <= idx_reg + 1'b1;
                end
            end
            if (frame_end) begin
                wr_bank_reg <= ~wr_bank_reg;
            end
            if (ack_take) begin
                rd_bank_reg <= ~rd_bank_reg;
            end
            tlast_unexpected_reg <= early_end;
            tlast_missing_reg    <= frame_end && !s_axis.tlast;
        end
    end

    // Memory write port.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Registered read from the current read bank, one cycle latency, independent of valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_reg <= '0;
        end else begin
            rd_data_reg <= mem[{rd_bank_reg, i_m_bram_add}];
        end
    end

    assign o32_m_bram_data    = rd_data_reg;
    assign o_m_data_valid     = full_reg[rd_bank_reg];
    assign o_tlast_unexpected = tlast_unexpected_reg;
    assign o_tlast_missing    = tlast_missing_reg;

endmodule

// File: tb/tb_axis2bram_capture_v1_0.sv
// Testbench for axis2bram_capture_v1_0: directed framing scenarios plus a randomized
// phase, all checked against a frame-level model (queue of stored frames).
module tb_axis2bram_capture_v1_0;
    localparam int AW  = 7;
    localparam int LSB = 0;
    localparam int N   = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] addr;
    logic [31:0]   rdata;
    logic          valid;
    logic          ack;
    logic          unexp;
    logic          miss;

    axis2bram_capture_v1_0_if ax();

    axis2bram_capture_v1_0 #(
        .p_addr_width (AW),
        .p_lane_lsb   (LSB)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .s_axis             (ax.slave),
        .i_m_bram_add       (addr),
        .o32_m_bram_data    (rdata),
        .o_m_data_valid     (valid),
        .i_m_frame_ack      (ack),
        .o_tlast_unexpected (unexp),
        .o_tlast_missing    (miss)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_frames = 0;

    // Model: committed frames back to back (oldest first), plus the frame being built.
    logic [31:0] store_q[$];
    logic [31:0] part_q[$];
    bit          pending;   // newest committed frame not yet visible (power mode only)

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [47:0] d);
        logic signed [15:0] re_s;
        logic signed [15:0] im_s;
        re_s = d[LSB +: 16];
        im_s = d[24 + LSB +: 16];
`ifdef AXIS2BRAM_POWER_EN
        return 32'(int'(re_s) * int'(re_s)) + 32'(int'(im_s) * int'(im_s));
`else
        return {im_s, re_s};
`endif
    endfunction

    // One clock: drive inputs, step the model across the edge, check outputs #1 after it.
    task automatic cycle(input bit r, input bit v, input logic [47:0] d, input bit l,
                         input bit a, input logic [AW-1:0] ad, output bit acc);
        int   frames;
        int   visible;
        bit   rdy;
        bit   exp_unexp;
        bit   exp_miss;
        bit   exp_data_chk;
        logic [31:0] exp_data;
        rst       = r;
        ax.tvalid = v;
        ax.tdata  = d;
        ax.tlast  = l;
        ack       = a;
        addr      = ad;
        #1;
        frames  = store_q.size() / N;
        visible = frames - (pending ? 1 : 0);
        rdy     = !r && (frames < 2);
        check_eq("tready", 32'(ax.tready), 32'(rdy));
        acc          = v && rdy;
        exp_unexp    = 1'b0;
        exp_miss     = 1'b0;
        exp_data_chk = 1'b0;
        exp_data     = '0;
        if (r) begin
            store_q.delete();
            part_q.delete();
            pending      = 1'b0;
            exp_data_chk = 1'b1;
            acc          = 1'b0;
        end else begin
            if (visible > 0) begin
                exp_data_chk = 1'b1;
                exp_data     = store_q[ad];
            end
            pending = 1'b0;
            if (a && visible > 0) begin
                repeat (N) void'(store_q.pop_front());
                $display("ack: frame released, %0d stored", store_q.size() / N);
            end
            if (acc) begin
                part_q.push_back(word_of(d));
                if (part_q.size() == N) begin
                    foreach (part_q[i]) store_q.push_back(part_q[i]);
                    part_q.delete();
                    exp_miss = !l;
                    n_frames++;
`ifdef AXIS2BRAM_POWER_EN
                    pending = 1'b1;
`endif
                    $display("commit: frame %0d tlast_missing=%0b", n_frames, !l);
                end else if (l) begin
                    $display("drop: early tlast after %0d beats", part_q.size());
                    part_q.delete();
                    exp_unexp = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        visible = store_q.size() / N - (pending ? 1 : 0);
        check_eq("data_valid", 32'(valid), 32'(visible > 0));
        check_eq("tlast_unexpected", 32'(unexp), 32'(exp_unexp));
        check_eq("tlast_missing", 32'(miss), 32'(exp_miss));
        if (exp_data_chk) begin
            check_eq("bram_data", rdata, exp_data);
        end
    endtask

    // Send a run of beats; pattern 0 random, 1 ramp re=k im=-k, 2 power corner values.
    task automatic send_beats(input int nbeats, input int tlast_at, input int pattern,
                              output logic [47:0] first_d);
        bit acc;
        int tries;
        logic [47:0] d;
        first_d = '0;
        for (int b = 0; b < nbeats; b++) begin
            d = {16'($urandom), 32'($urandom)};
            if (pattern == 1) begin
                d = {24'(-b), 24'(b)};
            end else if (pattern == 2 && b == 0) begin
                d = {24'h007FFF, 24'h007FFF};
            end else if (pattern == 2 && b == 1) begin
                d = {24'hFF8000, 24'hFF8000};
            end
            if (b == 0) first_d = d;
            acc   = 1'b0;
            tries = 0;
            while (!acc && tries < 1000) begin
                cycle(1'b0, 1'b1, d, (b == tlast_at), 1'b0, AW'($urandom), acc);
                tries++;
            end
            if (!acc) check_eq("accept_timeout", 32'(acc), 32'd1);
        end
    endtask

    task automatic idle(input bit a, input logic [AW-1:0] ad);
        bit acc;
        cycle(1'b0, 1'b0, '0, 1'b0, a, ad, acc);
    endtask

    task automatic do_reset();
        bit acc;
        repeat (2) cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, acc);
    endtask

    initial begin
        bit          acc;
        logic [47:0] d0;
        logic [47:0] next_first;
        bit          v;
        bit          l;
        bit          a;
        bit          r;

        pending = 1'b0;
        do_reset();

        // Basic frame: ramp data, valid latency, fixed read-back value.
        send_beats(N, N-1, 1, d0);
`ifdef AXIS2BRAM_POWER_EN
        check_eq("valid_at_T1", 32'(valid), 32'd0);
        idle(1'b0, '0);
        check_eq("valid_at_T2", 32'(valid), 32'd1);
        idle(1'b0, AW'(5));
        check_eq("read_addr5", rdata, 32'd50);
`else
        check_eq("valid_at_T1", 32'(valid), 32'd1);
        idle(1'b0, AW'(5));
        check_eq("read_addr5", rdata, 32'hFFFB0005);
`endif

`ifdef AXIS2BRAM_POWER_EN
        // Power corner values.
        do_reset();
        send_beats(N, N-1, 2, d0);
        idle(1'b0, '0);
        idle(1'b0, AW'(0));
        check_eq("power_7fff", rdata, 32'h7FFE0002);
        idle(1'b0, AW'(1));
        check_eq("power_8000", rdata, 32'h80000000);
`endif

        // Backpressure: two frames fill both banks, third waits for an ack.
        do_reset();
        send_beats(N, N-1, 0, d0);
        send_beats(N, N-1, 0, d0);
        check_eq("bp_tready_low", 32'(ax.tready), 32'd0);
        repeat (5) cycle(1'b0, 1'b1, {16'($urandom), 32'($urandom)}, 1'b0, 1'b0, AW'($urandom), acc);
        idle(1'b1, '0);
        check_eq("bp_tready_after_ack", 32'(ax.tready), 32'd1);
        check_eq("bp_valid_after_ack", 32'(valid), 32'd1);
        for (int i = 0; i < 8; i++) idle(1'b0, AW'($urandom));
        send_beats(N, N-1, 0, d0);
        idle(1'b0, '0);
        idle(1'b1, '0);
        idle(1'b1, '0);

        // Early tlast on beat 50.
        do_reset();
        send_beats(51, 50, 0, d0);
        check_eq("early_pulse", 32'(unexp), 32'd1);
        check_eq("early_valid", 32'(valid), 32'd0);
        idle(1'b0, '0);
        check_eq("early_pulse_once", 32'(unexp), 32'd0);
        send_beats(N, N-1, 0, d0);
        idle(1'b0, '0);
        check_eq("early_then_commit", 32'(valid), 32'd1);

        // Missing tlast: beat 128 becomes address 0 of the next frame.
        do_reset();
        send_beats(N, -1, 0, d0);
        check_eq("missing_pulse", 32'(miss), 32'd1);
        idle(1'b0, '0);
        check_eq("missing_valid", 32'(valid), 32'd1);
        check_eq("missing_pulse_once", 32'(miss), 32'd0);
        send_beats(N, N-1, 0, next_first);
        idle(1'b0, '0);
        idle(1'b1, '0);
        idle(1'b0, AW'(0));
        check_eq("missing_next_addr0", rdata, word_of(next_first));

        // Reset mid-frame with one bank full.
        do_reset();
        send_beats(N, N-1, 0, d0);
        send_beats(64, -1, 0, d0);
        cycle(1'b1, 1'b1, '0, 1'b0, 1'b0, '0, acc);
        check_eq("rst_valid", 32'(valid), 32'd0);
        idle(1'b0, '0);
        check_eq("rst_tready", 32'(ax.tready), 32'd1);
        send_beats(N, N-1, 0, d0);
        idle(1'b0, '0);
        for (int i = 0; i < N; i++) idle(1'b0, AW'(i));
        idle(1'b1, '0);

        // Randomized traffic.
        for (int c = 0; c < 4000; c++) begin
            v = ($urandom_range(0, 9) < 8);
            l = (part_q.size() == N-1) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 299) == 0);
            a = ($urandom_range(0, 29) == 0);
            r = ($urandom_range(0, 1999) == 0);
            cycle(r, v, {16'($urandom), 32'($urandom)}, l, a, AW'($urandom), acc);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
